// File: rtl/amm_pattern_master.sv
// amm_pattern_master: Avalon-MM master that writes a seed+index pattern to a block, reads it back pipelined and checks it
module amm_pattern_master #(
  parameter int ADDR_W      = 26,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter int ADDR_STRIDE = 1,
  parameter int MAX_PENDING = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    word_count,
  input  logic [DATA_W-1:0]   seed,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic [3:0]          avm_burstcount,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CNT_W-1:0]    error_count,
  output logic [ADDR_W-1:0]   first_err_addr
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FINISH} state_t;
  state_t            state, state_n;
  logic [ADDR_W-1:0] base, req_addr, cmp_addr;
  logic [CNT_W-1:0]  count, idx, cmp;
  logic [DATA_W-1:0] pat_seed;
  logic [3:0]        pending;
  logic              wr_acc, rd_acc, ret, last_idx, mismatch, launch;

  assign avm_byteenable = '1;
  assign avm_burstcount = 4'd1;

  // State register; reset always lands in IDLE so all requests drop at once
  always_ff @(posedge clk) state <= !reset_n ? IDLE : state_n;

  // Request outputs, handshake decode and next-state selection
  always_comb begin
    req_addr      = base + ADDR_W'(ADDR_STRIDE) * ADDR_W'(idx);
    cmp_addr      = base + ADDR_W'(ADDR_STRIDE) * ADDR_W'(cmp);
    avm_write     = state == WRITE;
    avm_read      = state == READ && pending < 4'(MAX_PENDING);
    avm_address   = (avm_write || avm_read) ? req_addr : '0;
    avm_writedata = avm_write ? pat_seed + DATA_W'(idx) : '0;
    wr_acc        = avm_write && !avm_waitrequest;
    rd_acc        = avm_read && !avm_waitrequest;
    ret           = avm_readdatavalid && pending != 4'd0;
    mismatch      = ret && avm_readdata != pat_seed + DATA_W'(cmp);
    last_idx      = idx == count - 1'b1;
    launch        = state == IDLE && busy;
    done          = state == FINISH;
    state_n       = state;
    unique case (state)
      IDLE:    state_n = launch ? (count == '0 ? FINISH : WRITE) : IDLE;
      WRITE:   state_n = wr_acc && last_idx ? READ : WRITE;
      READ:    state_n = rd_acc && last_idx ? DRAIN : READ;
      DRAIN:   state_n = cmp == count && pending == 4'd0 ? FINISH : DRAIN;
      default: state_n = IDLE;
    endcase
  end

  // Run parameters, word indices, outstanding-read count and result registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base           <= '0;
      count          <= '0;
      pat_seed       <= '0;
      idx            <= '0;
      cmp            <= '0;
      pending        <= '0;
      busy           <= 1'b0;
      pass           <= 1'b0;
      error_count    <= '0;
      first_err_addr <= '0;
    end else begin
      if (state == IDLE && !busy && start) begin
        base           <= base_addr;
        count          <= word_count;
        pat_seed       <= seed;
        idx            <= '0;
        cmp            <= '0;
        busy           <= 1'b1;
        pass           <= 1'b0;
        error_count    <= '0;
        first_err_addr <= '0;
      end
      if (state == FINISH) begin
        busy <= 1'b0;
        pass <= error_count == '0;
      end
      if (wr_acc) idx <= last_idx ? '0 : idx + 1'b1;
      if (rd_acc) idx <= idx + 1'b1;
      pending <= pending + 4'(rd_acc) - 4'(ret);
      if (ret) cmp <= cmp + 1'b1;
      if (mismatch && error_count != '1) error_count <= error_count + 1'b1;
      if (mismatch && error_count == '0) first_err_addr <= cmp_addr;
    end
  end
endmodule

// File: doc/amm_pattern_master.md
Name: amm_pattern_master

Overview:
- Avalon-MM master that sits directly upstream of the Avalon-MM slave (memory model / SDRAM-side slave) in the DE2i-150 system.
- On a start pulse it writes a deterministic data pattern to a block of words, then reads the block back with pipelined reads and compares each returned word against the expected value.
- Reports busy/done/pass plus an error count and the first failing address, for use as a bring-up and regression memory checker.

Parameters:
- ADDR_W, 26, Avalon address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- CNT_W, 16, width of the word-count and error-count fields.
- ADDR_STRIDE, 1, address increment per word (1 = word addressing, 4 = byte addressing).
- MAX_PENDING, 4, maximum outstanding reads (1..15).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  one-cycle start request
- base_addr  in  ADDR_W  first word address, sampled at start
- word_count  in  CNT_W  number of words, sampled at start
- seed  in  DATA_W  pattern seed, sampled at start
- avm_address  out  ADDR_W  Avalon address
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_writedata  out  DATA_W  write data
- avm_byteenable  out  DATA_W/8  always all ones
- avm_burstcount  out  4  always 1
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DATA_W  read data
- avm_readdatavalid  in  1  read data valid
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- pass  out  1  result of the last run, zero errors
- error_count  out  CNT_W  mismatches in the last run, saturating
- first_err_addr  out  ADDR_W  address of the first mismatch

Behaviour:
- Clock and reset: single clock clk. reset_n is synchronous and active-low. Reset returns the FSM to IDLE and clears the pending-read count.
- Reset values: avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, busy=0, done=0, pass=0, error_count=0, first_err_addr=0.
- Pattern: word i (0-based) has address A(i) = base_addr + i*ADDR_STRIDE, mod 2^ADDR_W (wraps silently). Its data is D(i) = seed + i, mod 2^DATA_W.
- FSM states: IDLE, WRITE, READ, DRAIN, FINISH.
- IDLE:
  - start=1 latches base_addr, word_count and seed, clears error_count, first_err_addr and pass, and sets busy the next cycle.
  - word_count=0 goes directly to FINISH with zero errors.
  - Otherwise the FSM enters WRITE with i=0.
  - start is ignored in every state except IDLE.
- WRITE:
  - avm_write=1 with A(i)/D(i).
  - Request signals are held stable while avm_waitrequest=1.
  - A write is accepted on a cycle with avm_write=1 and avm_waitrequest=0. On acceptance i increments.
  - After word_count-1 is accepted, the next cycle enters READ with issue index r=0 and compare index c=0. There are no idle cycles between accepted writes.
- READ:
  - avm_read=1 with A(r) whenever pending < MAX_PENDING. Otherwise avm_read=0.
  - A read is accepted on avm_read=1 and avm_waitrequest=0. On acceptance pending increments and r increments.
  - After r reaches word_count, the FSM moves to DRAIN.
  - Reads and writes are never asserted together.
- Read returns, in READ or DRAIN: each avm_readdatavalid=1 decrements pending and compares avm_readdata to D(c), then c increments.
  - A simultaneous accept and return leaves pending unchanged.
  - On mismatch, error_count increments, saturating at 2^CNT_W-1.
  - On the first mismatch of a run, first_err_addr is set to A(c).
  - avm_readdatavalid with pending=0 is ignored.
- DRAIN: when c = word_count and pending=0, the FSM goes to FINISH.
- FINISH: lasts one cycle. done=1, pass=(error_count==0), busy=0 on exit, then IDLE.
- pass, error_count and first_err_addr hold until the next accepted start.
- Latency: the first write request appears on the cycle after busy rises, i.e. 2 cycles after start. With waitrequest=0 and fixed slave read latency L, total run time is roughly 2N + L + 3 cycles.
- Reset mid-operation: all requests drop the same cycle reset_n=0 is sampled. Read data that arrives later is ignored, since pending=0.

Test Plan:
- base_addr=0x10, word_count=4, seed=0x1000, no waitrequest, read latency 3 -> writes 0x1000..0x1003 to 0x10..0x13, 4 reads, done pulse, pass=1, error_count=0.
- Same run with avm_waitrequest held high 2 cycles per command -> request signals stable during stalls, same writes and reads, pass=1.
- Slave corrupts the word at 0x12 to 0xDEAD -> error_count=1, first_err_addr=0x12, pass=0.
- MAX_PENDING=4, word_count=16, read latency 8 -> outstanding reads never exceed 4, all 16 compared in order, pass=1.
- word_count=0 -> done 2 cycles after start, no avm_read/avm_write asserted, pass=1. A start asserted while busy -> ignored, and the run in progress is unaffected.
- reset_n low for 1 cycle during READ with 3 reads pending -> avm_read=0, busy=0 next cycle, late readdatavalid ignored. A fresh start then completes with pass=1.
